// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Purpose : bundles the MEM/WB-to-writeback signals, the two ID-stage read
//           ports and the writeback-stage outputs into one interface.
// Signals : regWriteW, resultSrcW[1:0], ALUResultW, RDW, PCPlus4W, extImmW,
//           RdW[4:0]   - writeback request from the MEM/WB register
//           A1, A2     - ID-stage read addresses
//           RD1, RD2   - ID-stage read data
//           resultW    - selected writeback value (forwarding source)
//           wrCount    - committed register-write counter
// Modports: master drives requests and read addresses, slave is the regfile.
interface wb_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             regWriteW;
  logic [1:0]       resultSrcW;
  logic [XLEN-1:0]  ALUResultW;
  logic [XLEN-1:0]  RDW;
  logic [XLEN-1:0]  PCPlus4W;
  logic [XLEN-1:0]  extImmW;
  logic [4:0]       RdW;
  logic [4:0]       A1;
  logic [4:0]       A2;
  logic [XLEN-1:0]  RD1;
  logic [XLEN-1:0]  RD2;
  logic [XLEN-1:0]  resultW;
  logic [CNT_W-1:0] wrCount;

  modport master (
    output regWriteW, resultSrcW, ALUResultW, RDW, PCPlus4W, extImmW, RdW,
    output A1, A2,
    input  RD1, RD2, resultW, wrCount
  );

  modport slave (
    input  regWriteW, resultSrcW, ALUResultW, RDW, PCPlus4W, extImmW, RdW,
    input  A1, A2,
    output RD1, RD2, resultW, wrCount
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
// Purpose : writeback stage of the pipeline. Selects the final result,
//           writes it into the 32-entry integer register file, serves the
//           two combinational ID-stage read ports and counts committed writes.
// Ports   : clk      - clock
//           rst      - asynchronous, active-high reset (clears x1..x31 and
//                      the write counter, forces read ports to 0)
//           wbBus    - wb_regfile_if.slave (see interface header)
// Options : define WB_BYPASS_EN to make a read of the register being written
//           this cycle return resultW (write-through). Without it, reads
//           return the stored pre-write value until the clock edge.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  wbBus
);

  // x0 is hardwired to zero, so storage only exists for x1..x31.
  logic [XLEN-1:0]  r_regs [1:NREGS-1];
  logic [CNT_W-1:0] r_wrCount;

  logic [XLEN-1:0]  w_result;
  logic             w_commit;
  logic [XLEN-1:0]  w_rd1;
  logic [XLEN-1:0]  w_rd2;

  // Result select is purely combinational so it can feed forwarding paths.
  always_comb begin
    w_result = wbBus.ALUResultW;
    unique case (wbBus.resultSrcW)
      2'b00: w_result = wbBus.ALUResultW;
      2'b01: w_result = wbBus.RDW;
      2'b10: w_result = wbBus.PCPlus4W;
      2'b11: w_result = wbBus.extImmW;
      default: w_result = wbBus.ALUResultW;
    endcase
  end

  // Writes to x0 are dropped here, which also keeps them out of the counter.
  assign w_commit = wbBus.regWriteW && (wbBus.RdW != 5'd0);

  // Register array and counter share the async reset; an edge that arrives
  // while rst is high never commits the pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wrCount <= '0;
    end else if (w_commit) begin
      r_regs[wbBus.RdW] <= w_result;
      r_wrCount         <= r_wrCount + 1'b1;
    end
  end

  // Read port 1. Reset forces 0 even if a bypass would otherwise apply.
  always_comb begin
    w_rd1 = '0;
    if (!rst && (wbBus.A1 != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (w_commit && (wbBus.A1 == wbBus.RdW)) begin
        w_rd1 = w_result;
      end else begin
        w_rd1 = r_regs[wbBus.A1];
      end
`else
      w_rd1 = r_regs[wbBus.A1];
`endif
    end
  end

  // Read port 2, identical rules to port 1.
  always_comb begin
    w_rd2 = '0;
    if (!rst && (wbBus.A2 != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (w_commit && (wbBus.A2 == wbBus.RdW)) begin
        w_rd2 = w_result;
      end else begin
        w_rd2 = r_regs[wbBus.A2];
      end
`else
      w_rd2 = r_regs[wbBus.A2];
`endif
    end
  end

  assign wbBus.RD1     = w_rd1;
  assign wbBus.RD2     = w_rd2;
  assign wbBus.resultW = w_result;
  assign wbBus.wrCount = r_wrCount;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Purpose : randomized and directed stimulus for wb_regfile with a
//           queue-based scoreboard. The counter is built 4 bits wide so
//           wrap-around happens many times during the run.
// Ports   : none (top-level bench).
module tb_wb_regfile;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  wb_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.XLEN(XLEN), .NREGS(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .wbBus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-response queue entry: sel 0=RD1, 1=RD2, 2=resultW, 3=wrCount.
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t checkQ[$];
  int   testsRun;
  int   testsFailed;

  // Reference state: architectural register values and write count.
  logic [31:0] model [32];
  int unsigned modelCount;

  function automatic logic [31:0] modelResult(input logic [1:0] src,
                                              input logic [31:0] alu,
                                              input logic [31:0] rdw,
                                              input logic [31:0] pc4,
                                              input logic [31:0] imm);
    logic [31:0] vals [4];
    vals[0] = alu;
    vals[1] = rdw;
    vals[2] = pc4;
    vals[3] = imm;
    return vals[src];
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a,
                                            input logic rstIn,
                                            input logic we,
                                            input logic [4:0] rd,
                                            input logic [31:0] res);
    if (rstIn || a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && rd != 5'd0 && a == rd) return res;
`endif
    return model[a];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    modelCount = 0;
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] er,
                            input logic [31:0] ec);
    checkQ.push_back('{{tag, ".RD1"}, 0, e1});
    checkQ.push_back('{{tag, ".RD2"}, 1, e2});
    checkQ.push_back('{{tag, ".resultW"}, 2, er});
    checkQ.push_back('{{tag, ".wrCount"}, 3, ec});
  endtask

  // Drives one cycle of inputs (called just after a posedge), queues the
  // expected combinational outputs, then advances past the next posedge and
  // updates the reference state if a write commits there.
  task automatic applyStimulus(input logic rstIn, input logic we,
                               input logic [1:0] src,
                               input logic [31:0] alu, input logic [31:0] rdw,
                               input logic [31:0] pc4, input logic [31:0] imm,
                               input logic [4:0] rd, input logic [4:0] a1,
                               input logic [4:0] a2, input string tag);
    logic [31:0] res;
    rst            = rstIn;
    bus.regWriteW  = we;
    bus.resultSrcW = src;
    bus.ALUResultW = alu;
    bus.RDW        = rdw;
    bus.PCPlus4W   = pc4;
    bus.extImmW    = imm;
    bus.RdW        = rd;
    bus.A1         = a1;
    bus.A2         = a2;
    if (rstIn) modelClear();
    res = modelResult(src, alu, rdw, pc4, imm);
    pushExpect(tag, modelRead(a1, rstIn, we, rd, res),
               modelRead(a2, rstIn, we, rd, res), res,
               modelCount % (1 << CNT_W));
    @(posedge clk);
    if (!rstIn && we && rd != 5'd0) begin
      model[rd]  = res;
      modelCount = modelCount + 1;
    end
    #1;
  endtask

  // Asserts rst for part of a cycle only, never across a clock edge.
  task automatic pulseReset(input logic [4:0] a1, input logic [4:0] a2,
                            input string tag);
    logic [31:0] res;
    bus.regWriteW = 1'b0;
    bus.A1        = a1;
    bus.A2        = a2;
    rst           = 1'b1;
    modelClear();
    res = modelResult(bus.resultSrcW, bus.ALUResultW, bus.RDW, bus.PCPlus4W,
                      bus.extImmW);
    pushExpect(tag, 32'd0, 32'd0, res, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes every queued expectation at the negedge, away from the
  // active edge, comparing against the live DUT outputs.
  always @(negedge clk) begin
    while (checkQ.size() > 0) begin
      chk_t        c;
      logic [31:0] got;
      c = checkQ.pop_front();
      case (c.sel)
        0:       got = bus.RD1;
        1:       got = bus.RD2;
        2:       got = bus.resultW;
        default: got = {{(32-CNT_W){1'b0}}, bus.wrCount};
      endcase
      testsRun++;
      if (got !== c.exp) begin
        testsFailed++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", c.name, got,
                 c.exp);
      end
    end
  end

  initial begin
    logic        we;
    logic [4:0]  rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    testsRun    = 0;
    testsFailed = 0;
    modelClear();
    rst            = 1'b1;
    bus.regWriteW  = 1'b0;
    bus.resultSrcW = 2'b00;
    bus.ALUResultW = '0;
    bus.RDW        = '0;
    bus.PCPlus4W   = '0;
    bus.extImmW    = '0;
    bus.RdW        = '0;
    bus.A1         = '0;
    bus.A2         = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held across an edge: reads are 0 and the write is discarded.
    applyStimulus(1, 1, 2'b00, 32'h99, 0, 0, 0, 5'd3, 5'd3, 5'd0, "rstHold");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd3, 5'd0, "afterRst");

    // Reset pulse between edges clears x5 and the counter.
    applyStimulus(0, 1, 2'b00, 32'h1234, 0, 0, 0, 5'd5, 5'd5, 5'd0, "wrX5");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0, "rdX5");
    pulseReset(5'd5, 5'd5, "rstPulse");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd5, 5'd5, "postPulse");

    // Result mux: each source into x1..x4.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(0, 1, 2'(s), 32'hA, 32'hB, 32'hC, 32'hD, 5'(s + 1),
                    5'd0, 5'd0, "muxWr");
    end
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, "muxRd12");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd3, 5'd4, "muxRd34");

    // x0 protection.
    applyStimulus(0, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 5'd0, 5'd0, 5'd0,
                  "x0Wr");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, "x0Rd");

    // Same-cycle read of the register being written.
    applyStimulus(0, 1, 2'b00, 32'h11, 0, 0, 0, 5'd7, 5'd0, 5'd0, "x7a");
    applyStimulus(0, 1, 2'b00, 32'h22, 0, 0, 0, 5'd7, 5'd7, 5'd7, "x7b");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd7, 5'd7, "x7c");

    // Write disabled.
    applyStimulus(0, 0, 2'b00, 32'h55, 0, 0, 0, 5'd9, 5'd9, 5'd9, "noWr");

    // Counter wrap: 16 writes bring a 4-bit counter back to its start.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 5'(10 + (i % 4)),
                    5'd10, 5'd11, "wrap");
    end

    // Randomized traffic including occasional reset cycles.
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 39) == 0), we,
                    2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    $urandom, rd, a1, a2, "rand");
    end

    @(negedge clk);
    #1;
    testsRun++;
    if (checkQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", checkQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
